// File: rtl/timer_capture.sv
// rtl/timer_capture.sv - input-capture timer: prescaled time base, edge capture, period measurement
module timer_capture #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             cap_in,
  input  logic [15:0]      psc,
  input  logic [1:0]       edge_sel,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] cap_val,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             cap_flag,
  output logic             ovr_flag,
  output logic             cap_irq
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FIRST = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q, hist_d;
  logic [1:0]             state_q, state_d;
  logic [15:0]            pre_q, pre_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       cap_val_q, cap_val_d;
  logic [CNT_W-1:0]       period_q, period_d;
  logic                   pv_q, pv_d;
  logic                   cap_flag_q, cap_flag_d;
  logic                   ovr_q, ovr_d;
  logic                   irq_q, irq_d;

  logic sync_last, rise, fall, hit, tick, capture;

  assign sync_last = sync_q[SYNC_STAGES-1];
  assign rise      = sync_last & ~hist_q;
  assign fall      = ~sync_last & hist_q;
  // A prescaler count beyond a newly lowered psc still ticks on the next cycle.
  assign tick      = (pre_q >= psc);
  assign capture   = en && (state_q != ST_IDLE) && hit;

  always_comb begin
    hit = 1'b0;
    case (edge_sel)
      2'b00:   hit = rise;
      2'b01:   hit = fall;
      2'b10:   hit = rise | fall;
      default: hit = 1'b0;
    endcase
  end

  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], cap_in};
    hist_d     = sync_last;
    state_d    = state_q;
    pre_d      = pre_q;
    cnt_d      = cnt_q;
    cap_val_d  = cap_val_q;
    period_d   = period_q;
    pv_d       = pv_q;
    cap_flag_d = cap_flag_q;
    ovr_d      = ovr_q;
    irq_d      = capture;

    if (!en) begin
      state_d = ST_IDLE;
      pre_d   = 16'd0;
      cnt_d   = '0;
      pv_d    = 1'b0;
    end else begin
      pre_d = tick ? 16'd0 : pre_q + 16'd1;
      cnt_d = tick ? cnt_q + CNT_W'(1) : cnt_q;
      case (state_q)
        ST_IDLE: state_d = ST_FIRST;
        ST_FIRST: begin
          if (capture) begin
            cap_val_d = cnt_q;
            period_d  = '0;
            pv_d      = 1'b0;
            state_d   = ST_RUN;
          end
        end
        ST_RUN: begin
          if (capture) begin
            period_d  = cnt_q - cap_val_q;
            cap_val_d = cnt_q;
            pv_d      = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // A capture overrides a simultaneous clear; overrun reflects the flag before this cycle.
    if (capture) begin
      cap_flag_d = 1'b1;
      ovr_d      = cap_flag_q | (ovr_q & ~clr);
    end else if (clr) begin
      cap_flag_d = 1'b0;
      ovr_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= '0;
      hist_q     <= 1'b0;
      state_q    <= ST_IDLE;
      pre_q      <= 16'd0;
      cnt_q      <= '0;
      cap_val_q  <= '0;
      period_q   <= '0;
      pv_q       <= 1'b0;
      cap_flag_q <= 1'b0;
      ovr_q      <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      hist_q     <= hist_d;
      state_q    <= state_d;
      pre_q      <= pre_d;
      cnt_q      <= cnt_d;
      cap_val_q  <= cap_val_d;
      period_q   <= period_d;
      pv_q       <= pv_d;
      cap_flag_q <= cap_flag_d;
      ovr_q      <= ovr_d;
      irq_q      <= irq_d;
    end
  end

  assign cnt          = cnt_q;
  assign cap_val      = cap_val_q;
  assign period       = period_q;
  assign period_valid = pv_q;
  assign cap_flag     = cap_flag_q;
  assign ovr_flag     = ovr_q;
  assign cap_irq      = irq_q;

endmodule
